and_arbiter: RTL and testbench

AND_ARBITER -- requirements
Module: and_arbiter

---
 rtl/and_arbiter.sv | 111 +++++++++++
 tb/tb_and_arbiter.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/and_arbiter.sv
// Four requesters share one bitwise-AND datapath through a single result register.
// Define AND_ARBITER_RR_EN for round-robin arbitration; otherwise lowest index wins.
module and_arbiter #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [3:0]         req_valid,
  input  logic [4*WIDTH-1:0] req_a,
  input  logic [4*WIDTH-1:0] req_b,
  output logic [3:0]         req_ready,
  output logic               rsp_valid,
  output logic [WIDTH-1:0]   rsp_data,
  output logic [1:0]         rsp_id,
  input  logic               rsp_ready,
  output logic [CNT_W-1:0]   op_count
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [WIDTH-1:0] r_data;
  logic [1:0]       r_id;
  logic [CNT_W-1:0] r_cnt;

  logic             w_permit;
  logic             w_accept;
  logic             w_hit;
  logic             w_grant;
  logic [1:0]       w_gidx;
  logic [1:0]       w_base;
  logic [WIDTH-1:0] w_and;

`ifdef AND_ARBITER_RR_EN
  logic [1:0] r_ptr;

  assign w_base = r_ptr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr <= 2'd0;
    end else if (w_grant) begin
      r_ptr <= w_gidx + 2'd1;
    end
  end
`else
  assign w_base = 2'd0;
`endif

  // rst_n gates the permit so req_ready drops as soon as reset asserts
  assign w_permit = rst_n && ((r_state == EMPTY) || rsp_ready);
  assign w_accept = (r_state == FULL) && rsp_ready;

  always_comb begin
    w_hit  = 1'b0;
    w_gidx = 2'd0;
    for (int k = 0; k < 4; k++) begin
      if (!w_hit && req_valid[w_base + 2'(k)]) begin
        w_hit  = 1'b1;
        w_gidx = w_base + 2'(k);
      end
    end
  end

  assign w_grant   = w_hit && w_permit;
  assign req_ready = w_grant ? (4'b0001 << w_gidx) : 4'b0000;
  assign w_and     = req_a[w_gidx*WIDTH +: WIDTH]
                   & req_b[w_gidx*WIDTH +: WIDTH];

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      EMPTY: if (w_grant) w_next = FULL;
      FULL:  if (w_accept && !w_grant) w_next = EMPTY;
      default: w_next = EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= EMPTY;
      r_data  <= '0;
      r_id    <= 2'd0;
    end else begin
      r_state <= w_next;
      if (w_grant) begin
        r_data <= w_and;
        r_id   <= w_gidx;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (w_accept && (r_cnt != '1)) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign rsp_valid = (r_state == FULL);
  assign rsp_data  = r_data;
  assign rsp_id    = r_id;
  assign op_count  = r_cnt;

endmodule

// File: tb/tb_and_arbiter.sv
// Self-checking bench for and_arbiter: directed scenarios plus random traffic
// compared against a transaction-level model of the arbiter.
module tb_and_arbiter;

  localparam int WIDTH = 16;
  localparam int CNT_W = 4;

  logic               clk;
  logic               rst_n;
  logic [3:0]         req_valid;
  logic [4*WIDTH-1:0] req_a;
  logic [4*WIDTH-1:0] req_b;
  logic [3:0]         req_ready;
  logic               rsp_valid;
  logic [WIDTH-1:0]   rsp_data;
  logic [1:0]         rsp_id;
  logic               rsp_ready;
  logic [CNT_W-1:0]   op_count;

  and_arbiter #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .req_valid(req_valid),
    .req_a(req_a),
    .req_b(req_b),
    .req_ready(req_ready),
    .rsp_valid(rsp_valid),
    .rsp_data(rsp_data),
    .rsp_id(rsp_id),
    .rsp_ready(rsp_ready),
    .op_count(op_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;

  // reference model: one result slot, a rotating start index, a saturating count
  bit               m_valid;
  logic [WIDTH-1:0] m_data;
  int               m_id;
  int               m_ptr;
  int               m_cnt;
  int               last_g;

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_valid = 0;
    m_data  = '0;
    m_id    = 0;
    m_ptr   = 0;
    m_cnt   = 0;
  endtask

  task automatic set_op(int i, logic [WIDTH-1:0] a, logic [WIDTH-1:0] b);
    req_a[i*WIDTH +: WIDTH] = a;
    req_b[i*WIDTH +: WIDTH] = b;
  endtask

  task automatic check_outputs();
    check("rsp_valid", 32'(rsp_valid), 32'(m_valid));
    check("rsp_data", 32'(rsp_data), 32'(m_data));
    check("rsp_id", 32'(rsp_id), 32'(m_id));
    check("op_count", 32'(op_count), 32'(m_cnt));
  endtask

  // called just after a rising edge with inputs already driven
  task automatic step();
    int  g;
    bit  permit;
    bit  acc;
    logic [3:0] exp_rr;
    #1;
    g      = -1;
    permit = !m_valid || rsp_ready;
    acc    = m_valid && rsp_ready;
    if (permit) begin
      for (int k = 0; k < 4; k++) begin
        if (g < 0 && req_valid[(m_ptr + k) % 4]) g = (m_ptr + k) % 4;
      end
    end
    exp_rr = (g >= 0) ? 4'(1 << g) : 4'b0000;
    check("req_ready", 32'(req_ready), 32'(exp_rr));
    @(posedge clk);
    if (g >= 0) begin
      m_valid = 1;
      m_data  = req_a[g*WIDTH +: WIDTH] & req_b[g*WIDTH +: WIDTH];
      m_id    = g;
`ifdef AND_ARBITER_RR_EN
      m_ptr   = (g + 1) % 4;
`endif
    end else if (acc) begin
      m_valid = 0;
    end
    if (acc && m_cnt < (1 << CNT_W) - 1) m_cnt++;
    last_g = g;
    #1;
    check_outputs();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    #1;
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_req_ready", 32'(req_ready), 32'd0);
    check("rst_op_count", 32'(op_count), 32'd0);
    check("rst_rsp_data", 32'(rsp_data), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n     = 1'b1;
    req_valid = 4'b0;
    req_a     = '0;
    req_b     = '0;
    rsp_ready = 1'b0;
    last_g    = -1;
    model_reset();
    #2;
    do_reset();
    check_outputs();

    // V1 single request
    req_valid = 4'b0001;
    set_op(0, 16'hF0F0, 16'h3C3C);
    rsp_ready = 1'b1;
    step();
    check("v1_grant", 32'(last_g), 32'd0);
    check("v1_data", 32'(rsp_data), 32'h3030);
    req_valid = 4'b0000;
    step();
    check("v1_count", 32'(op_count), 32'd1);

    // V2 backpressure
    req_valid = 4'b0001;
    set_op(0, 16'hABCD, 16'hFF00);
    rsp_ready = 1'b0;
    step();
    req_valid = 4'b0010;
    set_op(1, 16'h1234, 16'h0FF0);
    for (int i = 0; i < 5; i++) begin
      step();
      check("v2_hold", 32'(rsp_data), 32'hAB00);
    end
    rsp_ready = 1'b1;
    step();
    check("v2_grant", 32'(last_g), 32'd1);
    check("v2_data", 32'(rsp_data), 32'h0230);
    req_valid = 4'b0000;
    step();

    // V3 / V4 all requesters active
    do_reset();
    for (int i = 0; i < 4; i++) set_op(i, 16'(16'h1111 * (i + 1)), 16'hFFFF);
    req_valid = 4'b1111;
    rsp_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step();
`ifdef AND_ARBITER_RR_EN
      check("v3_order", 32'(last_g), 32'(i % 4));
`else
      check("v4_fixed", 32'(last_g), 32'd0);
`endif
    end
    req_valid = 4'b0000;
    step();
    step();
    check("v3_count", 32'(op_count), 32'd8);

    // V5 saturation after 20 accepts
    do_reset();
    req_valid = 4'b0100;
    set_op(2, 16'h5A5A, 16'hFFFF);
    rsp_ready = 1'b1;
    for (int i = 0; i < 21; i++) step();
    check("v5_sat", 32'(op_count), 32'hF);

    // V6 reset while FULL
    rsp_ready = 1'b0;
    step();
    check("v6_full", 32'(rsp_valid), 32'd1);
    req_valid = 4'b0000;
    do_reset();
    req_valid = 4'b1000;
    set_op(3, 16'hC3C3, 16'hFF0F);
    rsp_ready = 1'b1;
    step();
    check("v6_grant", 32'(last_g), 32'd3);
    check("v6_data", 32'(rsp_data), 32'hC303);

    // random traffic against the model
    for (int i = 0; i < 300; i++) begin
      req_valid = ($urandom_range(0, 7) == 0) ? 4'b0000 : 4'($urandom);
      req_a     = {$urandom, $urandom};
      req_b     = {$urandom, $urandom};
      rsp_ready = ($urandom_range(0, 3) != 0);
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
